// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared encodings for the PWM timer slice (count modes, direction).
// Revision: 1.0
// ============================================================================
package pwm_pkg;

    localparam logic [1:0] CMS_EDGE  = 2'b00;
    localparam logic [1:0] CMS_CDN   = 2'b01;
    localparam logic [1:0] CMS_CUP   = 2'b10;
    localparam logic [1:0] CMS_CBOTH = 2'b11;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic {
        PH_UP = 1'b0,
        PH_DN = 1'b1
    } phase_e;

endpackage
`default_nettype wire

// File: rtl/pwm_arr_shadow.sv
`default_nettype none
// ============================================================================
// Module  : pwm_arr_shadow
// Brief   : Preload/shadow register with load strobe and preload-enable mux.
// Revision: 1.0
// ============================================================================
module pwm_arr_shadow #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] preload,
    input  logic             arpe,
    output logic [WIDTH-1:0] act
);

    logic [WIDTH-1:0] shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= preload;
        end
    end

    assign act = arpe ? shadow : preload;

endmodule
`default_nettype wire

// File: rtl/pwm_timebase_counter.sv
`default_nettype none
// ============================================================================
// Module  : pwm_timebase_counter
// Brief   : Edge/center-aligned timer counter with update event and OPM.
// Revision: 1.0
// ============================================================================
module pwm_timebase_counter
    import pwm_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_psc_i,
    input  logic                 rst_i,
    input  logic                 cen_i,
    input  logic                 ck_cnt_i,
    input  logic [CNT_WIDTH-1:0] arr_preload_i,
    input  logic                 arpe_i,
    input  logic                 dir_i,
    input  logic [1:0]           cms_i,
    input  logic                 udis_i,
    input  logic                 ug_i,
    input  logic                 opm_i,
    input  logic                 uif_clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 dir_o,
    output logic                 uev_o,
    output logic                 uif_o,
    output logic                 cen_clr_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic [CNT_WIDTH-1:0] arr_act;
    phase_e               phase;
    phase_e               phase_nx;
    logic                 dir;
    logic                 dir_nx;
    logic                 uev;
    logic                 uif;
    logic                 cen_clr;
    logic                 opm_stop;
    logic                 edge_mode;
    logic                 step;
    logic                 ovf;
    logic                 udf;
    logic                 cnt_evt;
    logic                 uev_src;

    assign edge_mode = (cms_i == CMS_EDGE);
    assign step      = cen_i & ck_cnt_i & ~opm_stop;

    // Shadow loads on the same edge as the wrap, so the wrap itself sees the old value.
    pwm_arr_shadow #(
        .WIDTH (CNT_WIDTH)
    ) u_arr_shadow (
        .clk     (clk_psc_i),
        .rst     (rst_i),
        .load    (uev_src),
        .preload (arr_preload_i),
        .arpe    (arpe_i),
        .act     (arr_act)
    );

    always_comb begin
        cnt_nx   = cnt;
        phase_nx = edge_mode ? PH_UP : phase;
        ovf      = 1'b0;
        udf      = 1'b0;
        if (step) begin
            if (edge_mode) begin
                if (dir_i == DIR_UP) begin
                    if (cnt >= arr_act) begin
                        cnt_nx = '0;
                        ovf    = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_ONE;
                    end
                end else if (cnt == '0) begin
                    cnt_nx = arr_act;
                    udf    = 1'b1;
                end else begin
                    cnt_nx = cnt - CNT_ONE;
                end
            end else if (arr_act == '0) begin
                cnt_nx = '0;
                ovf    = 1'b1;
                udf    = 1'b1;
            end else if (phase == PH_UP) begin
                if (cnt >= arr_act) begin
                    cnt_nx   = arr_act - CNT_ONE;
                    phase_nx = PH_DN;
                    ovf      = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end else if (cnt == '0) begin
                cnt_nx   = CNT_ONE;
                phase_nx = PH_UP;
                udf      = 1'b1;
            end else begin
                cnt_nx = cnt - CNT_ONE;
            end
        end
        // Software update overrides any coincident step.
        if (ug_i) begin
            cnt_nx   = (edge_mode && dir_i == DIR_DN) ? arr_act : '0;
            phase_nx = PH_UP;
        end
        dir_nx = edge_mode ? dir_i : ((phase_nx == PH_DN) ? DIR_DN : DIR_UP);
    end

    assign cnt_evt = edge_mode ? (ovf | udf) : ((cms_i[1] & ovf) | (cms_i[0] & udf));
    assign uev_src = (cnt_evt & ~udis_i) | ug_i;

    always_ff @(posedge clk_psc_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            phase    <= PH_UP;
            dir      <= DIR_UP;
            uev      <= 1'b0;
            uif      <= 1'b0;
            cen_clr  <= 1'b0;
            opm_stop <= 1'b0;
        end else begin
            cnt      <= cnt_nx;
            phase    <= phase_nx;
            dir      <= dir_nx;
            uev      <= uev_src;
            uif      <= uev_src | (uif & ~uif_clr_i);
            cen_clr  <= cnt_evt & opm_i;
            opm_stop <= cen_i & (opm_stop | (cnt_evt & opm_i));
        end
    end

    assign cnt_o     = cnt;
    assign dir_o     = dir;
    assign uev_o     = uev;
    assign uif_o     = uif;
    assign cen_clr_o = cen_clr;

endmodule
`default_nettype wire

// File: tb/tb_pwm_timebase_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_pwm_timebase_counter
// Brief   : Directed scoreboard bench for pwm_timebase_counter.
// Revision: 1.0
// ============================================================================
module tb_pwm_timebase_counter;

    logic        clk = 1'b0;
    logic        rst, cen, ck, arpe, dir, udis, ug, opm, uclr;
    logic [15:0] arr;
    logic [1:0]  cms;
    logic [15:0] cnt_w;
    logic        dir_w, uev_w, uif_w, cclr_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] cnt;
        logic        dir;
        logic        uev;
        logic        uif;
        logic        cclr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pwm_timebase_counter #(.CNT_WIDTH(16)) dut (
        .clk_psc_i     (clk),
        .rst_i         (rst),
        .cen_i         (cen),
        .ck_cnt_i      (ck),
        .arr_preload_i (arr),
        .arpe_i        (arpe),
        .dir_i         (dir),
        .cms_i         (cms),
        .udis_i        (udis),
        .ug_i          (ug),
        .opm_i         (opm),
        .uif_clr_i     (uclr),
        .cnt_o         (cnt_w),
        .dir_o         (dir_w),
        .uev_o         (uev_w),
        .uif_o         (uif_w),
        .cen_clr_o     (cclr_w)
    );

    task automatic expect_now(input string tag, input int c, input bit d, input bit u,
                              input bit f, input bit cc);
        exp_t e;
        e.tag  = tag;
        e.cnt  = 16'(c);
        e.dir  = d;
        e.uev  = u;
        e.uif  = f;
        e.cclr = cc;
        exp_q.push_back(e);
    endtask

    // Expected values describe the outputs after the next rising edge.
    task automatic cyc(input string tag, input int c, input bit d, input bit u,
                       input bit f, input bit cc);
        @(posedge clk);
        expect_now(tag, c, d, u, f, cc);
        #2;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            checks = checks + 1;
            if (cnt_w !== mon_e.cnt || dir_w !== mon_e.dir || uev_w !== mon_e.uev ||
                uif_w !== mon_e.uif || cclr_w !== mon_e.cclr) begin
                errors = errors + 1;
                $display("FAIL %s: got cnt=%0d dir=%0b uev=%0b uif=%0b cen_clr=%0b, want cnt=%0d dir=%0b uev=%0b uif=%0b cen_clr=%0b",
                         mon_e.tag, cnt_w, dir_w, uev_w, uif_w, cclr_w,
                         mon_e.cnt, mon_e.dir, mon_e.uev, mon_e.uif, mon_e.cclr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int slow_exp [15] = '{2, 2, 2, 2, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 3};
        rst = 1'b1; cen = 1'b0; ck = 1'b0; arr = '0; arpe = 1'b0; dir = 1'b0;
        cms = 2'b00; udis = 1'b0; ug = 1'b0; opm = 1'b0; uclr = 1'b0;

        cyc("reset", 0, 0, 0, 0, 0);
        cyc("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Edge-aligned up count, ARR=4
        arr = 16'd4; cen = 1'b1; ck = 1'b1;
        for (int k = 1; k <= 4; k++) cyc("up", k, 0, 0, 0, 0);
        cyc("up_wrap", 0, 0, 1, 1, 0);
        cyc("up_after", 1, 0, 0, 1, 0);
        uclr = 1'b1;
        cyc("uif_clr", 2, 0, 0, 0, 0);
        uclr = 1'b0;
        cyc("up", 3, 0, 0, 0, 0);
        cyc("up", 4, 0, 0, 0, 0);
        udis = 1'b1;
        cyc("udis_wrap", 0, 0, 0, 0, 0);
        cyc("udis", 1, 0, 0, 0, 0);
        udis = 1'b0;

        cen = 1'b0;
        cyc("cen_hold", 1, 0, 0, 0, 0);
        cyc("cen_hold", 1, 0, 0, 0, 0);
        cen = 1'b1; arr = 16'd9;
        for (int k = 2; k <= 6; k++) cyc("count", k, 0, 0, 0, 0);
        // The 6->7 edge happens, then reset lands before the next edge.
        @(posedge clk); #2;
        rst = 1'b1;
        expect_now("async_rst", 0, 0, 0, 0, 0);
        cyc("rst_hold", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Edge-aligned down count, ARR=3
        dir = 1'b1; arr = 16'd3;
        cyc("dn_uf", 3, 1, 1, 1, 0);
        cyc("dn", 2, 1, 0, 1, 0);
        cyc("dn", 1, 1, 0, 1, 0);
        cyc("dn", 0, 1, 0, 1, 0);
        cyc("dn_uf", 3, 1, 1, 1, 0);
        uclr = 1'b1;
        cyc("dn_clr", 2, 1, 0, 0, 0);
        uclr = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ck = (i % 5 == 4);
            cyc("dn_slow", slow_exp[i], 1, i == 14, i == 14, 0);
        end
        ck = 1'b0; uclr = 1'b1;
        cyc("dn_clr", 3, 1, 0, 0, 0);
        uclr = 1'b0;

        // Center-aligned, both events, ARR=3 (dir_i held at 1 to show it is ignored)
        cms = 2'b11; ug = 1'b1;
        cyc("ctr_ug", 0, 0, 1, 1, 0);
        ug = 1'b0; ck = 1'b1; uclr = 1'b1;
        cyc("ctr", 1, 0, 0, 0, 0);
        uclr = 1'b0;
        cyc("ctr", 2, 0, 0, 0, 0);
        cyc("ctr", 3, 0, 0, 0, 0);
        cyc("ctr_top", 2, 1, 1, 1, 0);
        cyc("ctr", 1, 1, 0, 1, 0);
        cyc("ctr", 0, 1, 0, 1, 0);
        cyc("ctr_bot", 1, 0, 1, 1, 0);
        cyc("ctr", 2, 0, 0, 1, 0);

        // Center-aligned, event at bottom only
        cms = 2'b01; uclr = 1'b1;
        cyc("cdn", 3, 0, 0, 0, 0);
        uclr = 1'b0;
        cyc("cdn_top", 2, 1, 0, 0, 0);
        cyc("cdn", 1, 1, 0, 0, 0);
        cyc("cdn", 0, 1, 0, 0, 0);
        cyc("cdn_bot", 1, 0, 1, 1, 0);
        cyc("cdn", 2, 0, 0, 1, 0);

        // ARR preload: load 4 via UG, write 8 mid-period
        cms = 2'b00; dir = 1'b0; arpe = 1'b1; arr = 16'd4; ck = 1'b0; ug = 1'b1;
        cyc("pre_ug", 0, 0, 1, 1, 0);
        ug = 1'b0; ck = 1'b1; uclr = 1'b1;
        cyc("pre", 1, 0, 0, 0, 0);
        uclr = 1'b0;
        cyc("pre", 2, 0, 0, 0, 0);
        arr = 16'd8;
        cyc("pre", 3, 0, 0, 0, 0);
        cyc("pre", 4, 0, 0, 0, 0);
        cyc("pre_wrap4", 0, 0, 1, 1, 0);
        for (int k = 1; k <= 8; k++) cyc("pre", k, 0, 0, 1, 0);
        cyc("pre_wrap8", 0, 0, 1, 1, 0);

        // No preload: shrink ARR below the running count
        arpe = 1'b0;
        for (int k = 1; k <= 5; k++) cyc("direct", k, 0, 0, 1, 0);
        arr = 16'd2;
        cyc("shrink", 0, 0, 1, 1, 0);
        cyc("direct", 1, 0, 0, 1, 0);

        // UG coincident with overflow
        cyc("direct", 2, 0, 0, 1, 0);
        ug = 1'b1;
        cyc("ug_ovf", 0, 0, 1, 1, 0);
        ug = 1'b0;
        cyc("ug_ovf_single", 1, 0, 0, 1, 0);

        // One-pulse mode, ARR=2
        opm = 1'b1; ck = 1'b0; ug = 1'b1;
        cyc("opm_ug", 0, 0, 1, 1, 0);
        ug = 1'b0; ck = 1'b1; uclr = 1'b1;
        cyc("opm", 1, 0, 0, 0, 0);
        uclr = 1'b0;
        cyc("opm", 2, 0, 0, 0, 0);
        cyc("opm_wrap", 0, 0, 1, 1, 1);
        cyc("opm_halt", 0, 0, 0, 1, 0);
        cyc("opm_halt", 0, 0, 0, 1, 0);
        cyc("opm_halt", 0, 0, 0, 1, 0);
        cen = 1'b0;
        cyc("opm_release", 0, 0, 0, 1, 0);
        cen = 1'b1; opm = 1'b0;
        cyc("opm_restart", 1, 0, 0, 1, 0);

        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pwm_timebase_counter.md
Name: pwm_timebase_counter

Overview:
- Time-base counter stage directly downstream of pwm_prescaler. Consumes the prescaler's ck_cnt_o tick as a count enable.
- Produces the running counter value for compare/output stages, plus the update event (UEV) that reloads shadow registers.
- Supports edge-aligned up/down and center-aligned counting, ARR preload/shadow, update disable, software update and one-pulse mode.

Parameters:
- CNT_WIDTH, 16, width of counter and auto-reload value

Ports:
- clk_psc_i  in  1  timer clock (same domain as pwm_prescaler)
- rst_i  in  1  asynchronous reset, active-high
- cen_i  in  1  counter enable from control register
- ck_cnt_i  in  1  one-cycle count tick from pwm_prescaler ck_cnt_o
- arr_preload_i  in  CNT_WIDTH  auto-reload value written by software
- arpe_i  in  1  1: ARR buffered through shadow; 0: arr_preload_i used directly
- dir_i  in  1  0 up, 1 down (edge-aligned only)
- cms_i  in  2  00 edge; 01 center, event at bottom; 10 center, event at top; 11 center, both
- udis_i  in  1  suppress counter-generated UEV
- ug_i  in  1  one-cycle software update request
- opm_i  in  1  one-pulse mode
- uif_clr_i  in  1  clear update interrupt flag
- cnt_o  out  CNT_WIDTH  current counter value
- dir_o  out  1  current effective direction
- uev_o  out  1  one-cycle update event pulse (also feeds prescaler shadow load)
- uif_o  out  1  sticky update interrupt flag
- cen_clr_o  out  1  one-cycle pulse requesting the control register to clear CEN (OPM)

Behaviour:
- Reset (async, rst_i=1): cnt_o=0, arr_shadow=0, dir_o=0, phase=up, uev_o=0, uif_o=0, cen_clr_o=0, opm_stop=0.
- arr_act = arpe_i ? arr_shadow : arr_preload_i.
- Step occurs on a clock edge where cen_i & ck_cnt_i & !opm_stop. With no step, cnt_o holds.
- Edge up (cms=00, dir_i=0): cnt>=arr_act -> cnt=0, overflow; else cnt+1.
- Edge down (cms=00, dir_i=1): cnt==0 -> cnt=arr_act, underflow; else cnt-1.
- dir_o=dir_i in edge mode.
- Center (cms!=00): dir_i is ignored and dir_o reflects the phase.
  - Up phase: cnt>=arr_act -> cnt=arr_act-1, phase=down, overflow.
  - Down phase: cnt==0 -> cnt=1, phase=up, underflow.
  - arr_act=0: cnt stays 0; each step is both overflow and underflow.
- Counter event:
  - Edge mode: any overflow or underflow.
  - Center mode: overflow if cms[1], underflow if cms[0].
- UEV source: counter event & !udis_i, or ug_i. ug_i ignores udis_i.
- uev_o is registered: it pulses in the cycle after the triggering edge. Exactly one pulse even if ug_i and a counter event coincide.
- On a UEV source: arr_shadow <= arr_preload_i. The wrap value on that same step uses the old arr_act.
- ug_i: cnt=0 and phase=up, except edge down where cnt=arr_act. ug_i has priority over a coincident step. Allowed while cen_i=0.
- uif_o: set on every uev_o and held until uif_clr_i. A set in the same cycle as a clear wins.
- OPM: counter event with opm_i=1 sets opm_stop. cen_clr_o pulses together with the resulting uev_o. Counter halts at its wrapped value. opm_stop clears when cen_i=0.
- cms change takes effect on the next step; entering center mode forces phase=up.
- cen_i=0 freezes cnt_o but does not reset it.
- Reset mid-count returns every state to its reset value immediately.

Decomposition:
- Shared package pwm_pkg: cms encoding constants (CMS_EDGE=2'b00, CMS_CDN=2'b01, CMS_CUP=2'b10, CMS_CBOTH=2'b11) and DIR_UP/DIR_DN.
- Sub-module pwm_arr_shadow: preload/shadow register with load strobe and arpe mux. It is reusable for CCR shadows.

Test Plan:
- Reset/hold: rst_i=1 mid-count with cnt=7 -> all outputs 0 immediately. cen_i=0 with ticks present -> cnt_o frozen.
- Edge up, ARR=4, tick every cycle: cnt 0,1,2,3,4,0. uev_o pulses one cycle after the 4->0 edge, and uif_o sets. With udis_i=1: no uev_o, no uif.
- Edge down, ARR=3: cnt 3,2,1,0,3 with underflow UEV. Same sequence with a 1-in-5 tick rate (prescaler preload=4) -> cnt changes only on ticks.
- Center cms=11, ARR=3: cnt 0,1,2,3,2,1,0,1. UEV at 3 and at 0. dir_o toggles at the turnarounds. With cms=01, UEV only at 0.
- ARR preload: arpe_i=1, ARR=4 running, write 8 mid-period -> current period wraps at 4, next at 8. With arpe_i=0, shrinking ARR from 8 to 2 while cnt=5 -> wrap to 0 on the next tick.
- OPM/UG: opm_i=1, ARR=2 -> cnt 0,1,2,0, then halt. cen_clr_o and uev_o pulse once. ug_i coincident with overflow -> single uev_o, cnt=0.
